fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the team's synchronous FIFO (14-bit data, 64 entries) among several producers. Each producer presents data with a valid/ready handshake. The arbiter picks one requester per cycle and drives a registered write strobe and data into the FIFO. It never issues a write that the FIFO cannot accept, given the one-cycle write latency. Per-requester saturating accept counters are provided for debug.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_WIDTH, 14, FIFO data width
- FIFO_DEPTH, 64, FIFO entries (power of two)
- CNT_WIDTH, $clog2(FIFO_DEPTH), width of FIFO occupancy input

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  producer i has data
- req_data  in  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot (or zero) grant; combinational from current inputs and state
- fifo_full  in  1  FIFO full flag
- fifo_count  in  CNT_WIDTH  FIFO occupancy
- fifo_wr_en  out  1  registered write strobe to FIFO
- fifo_wr_data  out  DATA_WIDTH  registered write data
- wr_src  out  $clog2(NUM_REQ)  registered index of the producer whose data is on fifo_wr_data
- stat_sel  in  $clog2(NUM_REQ)  selects accept counter
- stat_clr  in  1  synchronous clear of all accept counters
- stat_count  out  16  accept counter of producer stat_sel (combinational mux of registers)

## Operation
- Handshake: a transfer from producer i occurs in a cycle where req_valid[i] && req_ready[i]. Producers hold valid/data until accepted. At most one req_ready bit is high per cycle.
- Admission (`space_ok`): `!fifo_full && !(fifo_wr_en && fifo_count == FIFO_DEPTH-1)`.
  - The second term accounts for the write already in flight.
  - The check is conservative: a simultaneous FIFO read is ignored.
- When `!space_ok`, req_ready = 0 and the pointer is unchanged.
- Round-robin:
  - Register `last` holds the index of the most recent winner.
  - Search order is last+1, last+2, …, last (modulo NUM_REQ). The first valid requester wins.
  - `last` updates only on a transfer.
- Write stage:
  - On a transfer, fifo_wr_en <= 1, fifo_wr_data <= req_data[winner], wr_src <= winner.
  - Otherwise fifo_wr_en <= 0. fifo_wr_data and wr_src hold their values.
- Counters:
  - One 16-bit counter per producer increments on each transfer and saturates at 16'hFFFF.
  - stat_clr has priority over an increment in the same cycle.
  - stat_sel values ≥ NUM_REQ read 0.
- Reset (rst high at a clock edge, any state):
  - last <= NUM_REQ-1, so producer 0 has first priority.
  - fifo_wr_en <= 0, fifo_wr_data <= 0, wr_src <= 0.
  - All counters <= 0.
  - While rst is high, req_ready = 0.
  - A write registered in the cycle before reset still reaches the FIFO, because it was issued before the edge.

## Timing
- Grant to FIFO write latency: 1 cycle. The transfer happens at edge t, and fifo_wr_en is high during cycle t+1.
- Throughput: one write per cycle while space_ok holds and any request is valid.
- Full boundary:
  - Grant at count 62 → count 63 next cycle with a write in flight → no grant that cycle.
  - Grant resumes the cycle after fifo_full deasserts.
- Fairness: with all NUM_REQ valid continuously, each producer is granted exactly once in every NUM_REQ consecutive grants.
- Reset outputs: req_ready 0, fifo_wr_en 0, fifo_wr_data 0, wr_src 0, stat_count 0.

## Test plan
- Reset, then only req_valid[2] with data 14'h0AB → req_ready = 4'b0100 in the first cycle; next cycle fifo_wr_en = 1, fifo_wr_data = 14'h0AB, wr_src = 2.
- All 4 valid for 8 cycles, FIFO empty → grant order 0,1,2,3,0,1,2,3; stat_count = 2 for each producer.
- Producers 1 and 3 valid, last = 1 → 3 wins, then 1, then 3, alternating.
- Continuous requests from an empty FIFO with no reads → exactly 64 writes, never a 65th. req_ready stays 0 while fifo_full = 1 and resumes one cycle after a read clears full.
- Assert rst mid-stream (last = 2) → the next cycle after reset release grants producer 0. Counters read 0 and fifo_wr_en is 0 during reset.
- Preload the counter to 16'hFFFE, then 3 grants → reads FFFF. stat_clr in the same cycle as a grant → reads 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; registered write strobe/data 1 cycle after grant.
// Backpressure: no grant while the FIFO is full or a write in flight would fill it.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH),
    parameter int SEL_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic [CNT_WIDTH-1:0]          fifo_count,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [SEL_W-1:0]              wr_src,
    input  logic [SEL_W-1:0]              stat_sel,
    input  logic                          stat_clr,
    output logic [15:0]                   stat_count
);

    logic [SEL_W-1:0]      r_last;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [SEL_W-1:0]      r_wr_src;
    logic [15:0]           r_cnt [NUM_REQ];

    logic                  w_space_ok;
    logic                  w_found;
    logic                  w_grant;
    logic [SEL_W-1:0]      w_winner;
    logic [DATA_WIDTH-1:0] w_win_data;

    // The in-flight write will occupy the last free slot, so hold off one cycle.
    assign w_space_ok = !fifo_full &&
                        !(r_wr_en && fifo_count == CNT_WIDTH'(FIFO_DEPTH - 1));

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_last) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = SEL_W'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    assign w_grant    = w_found && w_space_ok && !rst;
    assign req_ready  = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
    assign w_win_data = req_data[int'(w_winner) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= SEL_W'(NUM_REQ - 1);
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
        end else begin
            r_wr_en <= w_grant;
            if (w_grant) begin
                r_last    <= w_winner;
                r_wr_data <= w_win_data;
                r_wr_src  <= w_winner;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst || stat_clr) begin
                r_cnt[i] <= 16'h0000;
            end else if (w_grant && w_winner == SEL_W'(i) && r_cnt[i] != 16'hFFFF) begin
                r_cnt[i] <= r_cnt[i] + 16'h0001;
            end
        end
    end

    assign stat_count   = (int'(stat_sel) < NUM_REQ) ? r_cnt[stat_sel] : 16'h0000;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign wr_src       = r_wr_src;

endmodule
